// File: rtl/layer_compositor.sv
// layer_compositor
//   Registered, parametrised VGA layer mixer. It merges N_LAYERS pixel sources
//   into one RGB stream using strict priority or the legacy OR merge, delays
//   hsync/vsync to stay aligned with the colour pipeline, blanks the output
//   outside active video, blinks selected layers on a frame basis and flags
//   overlap between layers COLL_A and COLL_B once per frame.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   pix_en       pixel strobe; registers advance only when high
//   layer_rgb    per-layer colour, layer i at [i*3*COLOR_W +: 3*COLOR_W], {r,g,b}
//   layer_vld    per-layer opaque flag for the current pixel
//   blink_en     per-layer blink enable
//   hsync_in     horizontal sync from the timing generator
//   vsync_in     vertical sync from the timing generator
//   blank_in     high outside active video
//   rgb_out      composited pixel, 2 strobes after its inputs
//   hsync_out    hsync aligned with rgb_out
//   vsync_out    vsync aligned with rgb_out
//   blink_phase  1 = blinking layers currently visible
//   collision    COLL_A/COLL_B overlap occurred in the previous frame
//   coll_pulse   one-clock pulse at the frame boundary of a colliding frame
module layer_compositor #(
  parameter int N_LAYERS     = 4,
  parameter int COLOR_W      = 1,
  parameter int OR_MODE      = 1,
  parameter int BLINK_FRAMES = 30,
  parameter int COLL_A       = 1,
  parameter int COLL_B       = 2,
  parameter int SYNC_ACT     = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pix_en,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]             layer_vld,
  input  logic [N_LAYERS-1:0]             blink_en,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            blank_in,
  output logic [3*COLOR_W-1:0]            rgb_out,
  output logic                            hsync_out,
  output logic                            vsync_out,
  output logic                            blink_phase,
  output logic                            collision,
  output logic                            coll_pulse
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int RGB_W = N_LAYERS * PIX_W;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic SYNC_ON  = (SYNC_ACT != 0);
  localparam logic SYNC_OFF = (SYNC_ACT == 0);

  // stage 1
  logic [RGB_W-1:0]    s1_rgb_q, s1_rgb_d;
  logic [N_LAYERS-1:0] s1_vis_q, s1_vis_d;
  logic                s1_hs_q, s1_hs_d;
  logic                s1_vs_q, s1_vs_d;
  logic                s1_blank_q, s1_blank_d;

  // stage 2 / outputs
  logic [PIX_W-1:0]    rgb_q, rgb_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;

  // frame-level state
  logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                coll_acc_q, coll_acc_d;
  logic                collision_q, collision_d;
  logic                coll_pulse_q, coll_pulse_d;

  logic [N_LAYERS-1:0] vis;
  logic                frame_evt;
  logic                coll_hit;
  logic [PIX_W-1:0]    mix_col;
  logic [PIX_W-1:0]    prio_col;
  logic [PIX_W-1:0]    comp_col;

  assign vis = layer_vld & ~(blink_en & {N_LAYERS{~blink_phase_q}});

  // The stage-1 copy of vsync is the previous sampled value, so comparing
  // against it gives the edge into the active level.
  assign frame_evt = pix_en & (vsync_in == SYNC_ON) & (s1_vs_q != SYNC_ON);

  // Collision uses raw valid flags: a blinked-out sprite still collides.
  assign coll_hit = pix_en & ~blank_in & layer_vld[COLL_A] & layer_vld[COLL_B];

  // Walking upward, prio_col ends up holding the highest visible layer while
  // mix_col accumulates the legacy OR of every visible layer.
  always_comb begin
    mix_col  = '0;
    prio_col = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (s1_vis_q[i]) begin
        mix_col  = mix_col | s1_rgb_q[i*PIX_W +: PIX_W];
        prio_col = s1_rgb_q[i*PIX_W +: PIX_W];
      end
    end
    if ((OR_MODE == 0) || s1_vis_q[N_LAYERS-1]) begin
      comp_col = prio_col;
    end else begin
      comp_col = mix_col;
    end
    if (s1_blank_q) begin
      comp_col = '0;
    end
  end

  always_comb begin
    s1_rgb_d      = s1_rgb_q;
    s1_vis_d      = s1_vis_q;
    s1_hs_d       = s1_hs_q;
    s1_vs_d       = s1_vs_q;
    s1_blank_d    = s1_blank_q;
    rgb_d         = rgb_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    coll_acc_d    = coll_acc_q;
    collision_d   = collision_q;
    // the pulse lasts one clk even when the next strobe is far away
    coll_pulse_d  = 1'b0;

    if (pix_en) begin
      s1_rgb_d   = layer_rgb;
      s1_vis_d   = vis;
      s1_hs_d    = hsync_in;
      s1_vs_d    = vsync_in;
      s1_blank_d = blank_in;
      rgb_d      = comp_col;
      hs_d       = s1_hs_q;
      vs_d       = s1_vs_q;
    end

    if (frame_evt) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + FC_W'(1);
      end
      collision_d  = coll_acc_q;
      coll_pulse_d = coll_acc_q;
      // a hit on the boundary strobe belongs to the new frame
      coll_acc_d   = coll_hit;
    end else if (coll_hit) begin
      coll_acc_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rgb_q      <= '0;
      s1_vis_q      <= '0;
      s1_hs_q       <= SYNC_OFF;
      s1_vs_q       <= SYNC_OFF;
      s1_blank_q    <= 1'b1;
      rgb_q         <= '0;
      hs_q          <= SYNC_OFF;
      vs_q          <= SYNC_OFF;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      coll_acc_q    <= 1'b0;
      collision_q   <= 1'b0;
      coll_pulse_q  <= 1'b0;
    end else begin
      s1_rgb_q      <= s1_rgb_d;
      s1_vis_q      <= s1_vis_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_blank_q    <= s1_blank_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      coll_acc_q    <= coll_acc_d;
      collision_q   <= collision_d;
      coll_pulse_q  <= coll_pulse_d;
    end
  end

  assign rgb_out     = rgb_q;
  assign hsync_out   = hs_q;
  assign vsync_out   = vs_q;
  assign blink_phase = blink_phase_q;
  assign collision   = collision_q;
  assign coll_pulse  = coll_pulse_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench: two instances share all stimulus, one in legacy OR merge
// mode and one in strict priority mode, both blinking every 2 frames.
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [11:0] layer_rgb;
  logic [3:0]  layer_vld;
  logic [3:0]  blink_en;
  logic        hsync_in, vsync_in, blank_in;

  logic [2:0]  rgb_or, rgb_pr;
  logic        hs_or, hs_pr, vs_or, vs_pr;
  logic        bp_or, bp_pr, col_or, col_pr, cp_or, cp_pr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  layer_compositor #(.N_LAYERS(4), .COLOR_W(1), .OR_MODE(1), .BLINK_FRAMES(2),
                     .COLL_A(1), .COLL_B(2), .SYNC_ACT(0)) u_dut_or (
    .clk(clk), .rst(rst), .pix_en(pix_en), .layer_rgb(layer_rgb),
    .layer_vld(layer_vld), .blink_en(blink_en), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .blank_in(blank_in), .rgb_out(rgb_or),
    .hsync_out(hs_or), .vsync_out(vs_or), .blink_phase(bp_or),
    .collision(col_or), .coll_pulse(cp_or));

  layer_compositor #(.N_LAYERS(4), .COLOR_W(1), .OR_MODE(0), .BLINK_FRAMES(2),
                     .COLL_A(1), .COLL_B(2), .SYNC_ACT(0)) u_dut_pr (
    .clk(clk), .rst(rst), .pix_en(pix_en), .layer_rgb(layer_rgb),
    .layer_vld(layer_vld), .blink_en(blink_en), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .blank_in(blank_in), .rgb_out(rgb_pr),
    .hsync_out(hs_pr), .vsync_out(vs_pr), .blink_phase(bp_pr),
    .collision(col_pr), .coll_pulse(cp_pr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pack(input logic [2:0] l3, input logic [2:0] l2,
                                       input logic [2:0] l1, input logic [2:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick(input logic pen);
    pix_en = pen;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rgb(input string tag, input logic [2:0] exp_or, input logic [2:0] exp_pr);
    check({tag, "_or"}, 32'(rgb_or), 32'(exp_or));
    check({tag, "_pr"}, 32'(rgb_pr), 32'(exp_pr));
  endtask

  task automatic check_hs(input string tag, input logic exp);
    check({tag, "_or"}, 32'(hs_or), 32'(exp));
    check({tag, "_pr"}, 32'(hs_pr), 32'(exp));
  endtask

  // vsync falling edge, a held clock with pix_en low, then vsync released
  task automatic frame(input string tag, input logic exp_coll, input logic exp_phase);
    vsync_in = 1'b0;
    tick(1'b1);
    check({tag, "_pulse"}, 32'(cp_or), 32'(exp_coll));
    check({tag, "_coll"}, 32'(col_pr), 32'(exp_coll));
    check({tag, "_phase"}, 32'(bp_or), 32'(exp_phase));
    check({tag, "_phase_pr"}, 32'(bp_pr), 32'(exp_phase));
    tick(1'b0);
    check({tag, "_pulse_drop"}, 32'(cp_pr), 32'd0);
    check({tag, "_coll_hold"}, 32'(col_or), 32'(exp_coll));
    vsync_in = 1'b1;
    tick(1'b1);
    check({tag, "_vs_out"}, 32'(vs_or), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b1; layer_rgb = '0; layer_vld = '0; blink_en = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b0;

    // reset
    tick(1'b1); tick(1'b1); tick(1'b1);
    check_rgb("rst_rgb", 3'b000, 3'b000);
    check_hs("rst_hs", 1'b1);
    check("rst_vs", 32'(vs_pr), 32'd1);
    check("rst_phase", 32'(bp_or), 32'd1);
    check("rst_coll", 32'(col_or), 32'd0);
    check("rst_pulse", 32'(cp_pr), 32'd0);
    rst = 1'b0;

    // legacy merge vs priority
    layer_rgb = pack(3'b001, 3'b000, 3'b010, 3'b100);
    layer_vld = 4'b0011;
    tick(1'b1); tick(1'b1);
    check_rgb("merge01", 3'b110, 3'b010);
    layer_vld = 4'b1011;
    tick(1'b1);
    check_rgb("merge_lat1", 3'b110, 3'b010);
    tick(1'b1);
    check_rgb("top_wins", 3'b001, 3'b001);

    // priority, blanking and sync delay
    layer_rgb = pack(3'b000, 3'b011, 3'b100, 3'b000);
    layer_vld = 4'b0110;
    hsync_in  = 1'b0;
    tick(1'b1);
    check_hs("hs_lat1", 1'b1);
    hsync_in  = 1'b1;
    tick(1'b1);
    check_hs("hs_lat2", 1'b0);
    check_rgb("prio12", 3'b111, 3'b011);
    blank_in  = 1'b1;
    tick(1'b1);
    check_hs("hs_lat3", 1'b1);
    check_rgb("blank_lat1", 3'b111, 3'b011);
    tick(1'b1);
    check_rgb("blank", 3'b000, 3'b000);

    // collision
    blank_in = 1'b0; layer_vld = 4'b0000;
    frame("f1", 1'b1, 1'b1);
    layer_vld = 4'b0110; tick(1'b1);
    layer_vld = 4'b0000; tick(1'b1);
    frame("f2", 1'b1, 1'b0);
    tick(1'b1); tick(1'b1);
    frame("f3_clean", 1'b0, 1'b0);
    blank_in = 1'b1; layer_vld = 4'b0110; tick(1'b1);
    blank_in = 1'b0; layer_vld = 4'b0000; tick(1'b1);
    frame("f4_blank", 1'b0, 1'b1);
    vsync_in = 1'b0; layer_vld = 4'b0110;
    tick(1'b1);
    check("edge_hit_pulse", 32'(cp_or), 32'd0);
    check("edge_hit_coll", 32'(col_pr), 32'd0);
    vsync_in = 1'b1; layer_vld = 4'b0000;
    tick(1'b1);
    frame("f6_edge", 1'b1, 1'b0);

    // blink
    rst = 1'b1; tick(1'b1); rst = 1'b0;
    blink_en  = 4'b1000;
    layer_rgb = pack(3'b111, 3'b000, 3'b000, 3'b100);
    layer_vld = 4'b1001;
    tick(1'b1); tick(1'b1);
    check_rgb("blink_f0", 3'b111, 3'b111);
    frame("b1", 1'b0, 1'b1);
    tick(1'b1); tick(1'b1);
    check_rgb("blink_f1", 3'b111, 3'b111);
    frame("b2", 1'b0, 1'b0);
    tick(1'b1); tick(1'b1);
    check_rgb("blink_off", 3'b100, 3'b100);
    frame("b3", 1'b0, 1'b0);
    frame("b4", 1'b0, 1'b1);
    tick(1'b1); tick(1'b1);
    check_rgb("blink_on", 3'b111, 3'b111);

    // pix_en gating
    blink_en  = 4'b0000;
    layer_rgb = pack(3'b000, 3'b000, 3'b000, 3'b010);
    layer_vld = 4'b0001;
    hsync_in  = 1'b0;
    tick(1'b1);
    check_rgb("gate_s1", 3'b111, 3'b111);
    hsync_in  = 1'b1;
    tick(1'b0);
    check_rgb("gate_hold", 3'b111, 3'b111);
    check_hs("gate_hs_hold", 1'b1);
    tick(1'b1);
    check_rgb("gate_out", 3'b010, 3'b010);
    check_hs("gate_hs_out", 1'b0);
    tick(1'b0);
    check_rgb("gate_hold2", 3'b010, 3'b010);

    // mid-line reset
    rst = 1'b1;
    tick(1'b1);
    check_rgb("mrst_rgb", 3'b000, 3'b000);
    check_hs("mrst_hs", 1'b1);
    check("mrst_vs", 32'(vs_or), 32'd1);
    check("mrst_phase", 32'(bp_pr), 32'd1);
    rst = 1'b0;
    tick(1'b1);
    check_rgb("mrst_flush", 3'b000, 3'b000);
    tick(1'b1);
    check_rgb("mrst_resume", 3'b010, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
